// File: rtl/sort_ctrl_pkg.sv
// Shared widths, bin count and FSM encodings for the spike-rate sort sequencer and its sorter bench.
package sort_ctrl_pkg;

    localparam int FREQ_BIT       = 8;
    localparam int SPIKE_RATE_BIT = 3;
    localparam int NUM_BINS       = 5;

    typedef logic [FREQ_BIT-1:0]       freq_t;
    typedef logic [SPIKE_RATE_BIT-1:0] rate_t;
    typedef freq_t [NUM_BINS-1:0]      bins_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam rate_t MAX_RATE_IDX = rate_t'(NUM_BINS - 1);

    function automatic rate_t clamp_rate(input rate_t r);
        return (r > MAX_RATE_IDX) ? MAX_RATE_IDX : r;
    endfunction

endpackage

// File: rtl/sort_ctrl_if.sv
// Sample input, table handshake and overrun flag between a rate source/sorter and sort_ctrl.
interface sort_ctrl_if;
    import sort_ctrl_pkg::*;

    logic  rate_valid;
    rate_t rate_in;
    logic  table_ready;
    logic  table_valid;
    rate_t max_rate;
    freq_t freq1;
    freq_t freq2;
    freq_t freq3;
    freq_t freq4;
    freq_t freq5;
    logic  overrun;
`ifdef SORT_FORCE_RATE_EN
    logic  force_en;
    rate_t force_rate;

    modport master (
        output rate_valid, rate_in, table_ready, force_en, force_rate,
        input  table_valid, max_rate, freq1, freq2, freq3, freq4, freq5, overrun
    );
    modport slave (
        input  rate_valid, rate_in, table_ready, force_en, force_rate,
        output table_valid, max_rate, freq1, freq2, freq3, freq4, freq5, overrun
    );
`else
    modport master (
        output rate_valid, rate_in, table_ready,
        input  table_valid, max_rate, freq1, freq2, freq3, freq4, freq5, overrun
    );
    modport slave (
        input  rate_valid, rate_in, table_ready,
        output table_valid, max_rate, freq1, freq2, freq3, freq4, freq5, overrun
    );
`endif
endinterface

// File: rtl/sort_ctrl_rate_hist_bank.sv
// Five saturating live rate counters, cleared on frame end; bins_nxt exposes the value including this cycle's sample.
// Latency: counts land one edge after the sample; no backpressure, every valid sample is taken.
module rate_hist_bank
    import sort_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc_vld,
    input  rate_t inc_rate,
    input  logic  clr,
    output bins_t bins_nxt
);

    bins_t bins_q;
    bins_t bins_d;

    // Out-of-range rates match no bin, so they fall through untouched.
    always_comb begin
        bins_nxt = bins_q;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (inc_vld && (inc_rate == rate_t'(i)) && (bins_q[i] != '1)) begin
                bins_nxt[i] = bins_q[i] + freq_t'(1);
            end
        end
        bins_d = clr ? '0 : bins_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bins_q <= '0;
        end else begin
            bins_q <= bins_d;
        end
    end

endmodule

// File: rtl/sort_ctrl.sv
// Frame histogram snapshot, 4-cycle argmax scan, valid/ready table hand-off; table_valid 4 cycles after frame end.
// A frame ending outside IDLE is dropped with an overrun pulse. Optional SORT_FORCE_RATE_EN adds a max_rate override.
module sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic         CLK,
    input  logic         RST,
    sort_ctrl_if.slave   bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_end;
    bins_t            hist_nxt;

    state_t state_q, state_d;
    bins_t  snap_q, snap_d;
    rate_t  best_idx_q, best_idx_d;
    freq_t  best_cnt_q, best_cnt_d;
    rate_t  scan_idx_q, scan_idx_d;
    rate_t  max_rate_q, max_rate_d;
    logic   table_valid_q, table_valid_d;
    logic   overrun_q, overrun_d;
`ifdef SORT_FORCE_RATE_EN
    logic   force_en_q, force_en_d;
    rate_t  force_rate_q, force_rate_d;
`endif

    assign frame_end = bus.rate_valid && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign cnt_d     = frame_end      ? '0 :
                       bus.rate_valid ? cnt_q + CNT_W'(1) : cnt_q;

    rate_hist_bank u_hist (
        .clk      (CLK),
        .rst      (RST),
        .inc_vld  (bus.rate_valid),
        .inc_rate (bus.rate_in),
        .clr      (frame_end),
        .bins_nxt (hist_nxt)
    );

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        best_idx_d    = best_idx_q;
        best_cnt_d    = best_cnt_q;
        scan_idx_d    = scan_idx_q;
        max_rate_d    = max_rate_q;
        table_valid_d = table_valid_q;
        overrun_d     = 1'b0;
`ifdef SORT_FORCE_RATE_EN
        force_en_d    = force_en_q;
        force_rate_d  = force_rate_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (frame_end) begin
                    snap_d     = hist_nxt;
                    best_idx_d = '0;
                    best_cnt_d = hist_nxt[0];
                    scan_idx_d = rate_t'(1);
                    state_d    = ST_SCAN;
`ifdef SORT_FORCE_RATE_EN
                    force_en_d   = bus.force_en;
                    force_rate_d = clamp_rate(bus.force_rate);
`endif
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the earliest index on ties.
                if (snap_q[scan_idx_q] > best_cnt_q) begin
                    best_idx_d = scan_idx_q;
                    best_cnt_d = snap_q[scan_idx_q];
                end
                if (scan_idx_q == MAX_RATE_IDX) begin
                    max_rate_d    = best_idx_d;
`ifdef SORT_FORCE_RATE_EN
                    if (force_en_q) begin
                        max_rate_d = force_rate_q;
                    end
`endif
                    table_valid_d = 1'b1;
                    state_d       = ST_PRESENT;
                end else begin
                    scan_idx_d = scan_idx_q + rate_t'(1);
                end
            end
            ST_PRESENT: begin
                if (bus.table_ready) begin
                    table_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                table_valid_d = 1'b0;
            end
        endcase

        if (frame_end && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            snap_q        <= '0;
            best_idx_q    <= '0;
            best_cnt_q    <= '0;
            scan_idx_q    <= '0;
            max_rate_q    <= '0;
            table_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            snap_q        <= snap_d;
            best_idx_q    <= best_idx_d;
            best_cnt_q    <= best_cnt_d;
            scan_idx_q    <= scan_idx_d;
            max_rate_q    <= max_rate_d;
            table_valid_q <= table_valid_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef SORT_FORCE_RATE_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            force_en_q   <= 1'b0;
            force_rate_q <= '0;
        end else begin
            force_en_q   <= force_en_d;
            force_rate_q <= force_rate_d;
        end
    end
`endif

    assign bus.table_valid = table_valid_q;
    assign bus.max_rate    = max_rate_q;
    assign bus.overrun     = overrun_q;
    assign bus.freq1       = snap_q[0];
    assign bus.freq2       = snap_q[1];
    assign bus.freq3       = snap_q[2];
    assign bus.freq4       = snap_q[3];
    assign bus.freq5       = snap_q[4];

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl: an 8-sample-frame instance for function/overrun/reset, a 65535-sample one for saturation.
module tb_sort_ctrl;
    import sort_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ov_cnt = 0;
    int   lat;
    int   seq[8];

    always #5 clk = ~clk;

    sort_ctrl_if a_if ();
    sort_ctrl_if b_if ();

    sort_ctrl #(.FRAME_LEN(8), .CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (a_if.slave)
    );

    sort_ctrl #(.FRAME_LEN(65535), .CNT_W(16)) dut_sat (
        .CLK (clk),
        .RST (rst),
        .bus (b_if.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (a_if.overrun === 1'b1) ov_cnt++;
    endtask

    task automatic send8(input int s[8]);
        for (int i = 0; i < 8; i++) begin
            a_if.rate_valid = 1'b1;
            a_if.rate_in    = rate_t'(s[i]);
            tick();
        end
        a_if.rate_valid = 1'b0;
    endtask

    task automatic wait_tv(input bit sel, output int n);
        n = 0;
        while (((sel ? b_if.table_valid : a_if.table_valid) !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
    endtask

    task automatic expect_table(input string pfx, input int f1, input int f2, input int f3,
                                input int f4, input int f5, input int mx);
        check({pfx, "_tv"},    int'(a_if.table_valid), 1);
        check({pfx, "_freq1"}, int'(a_if.freq1), f1);
        check({pfx, "_freq2"}, int'(a_if.freq2), f2);
        check({pfx, "_freq3"}, int'(a_if.freq3), f3);
        check({pfx, "_freq4"}, int'(a_if.freq4), f4);
        check({pfx, "_freq5"}, int'(a_if.freq5), f5);
        check({pfx, "_max"},   int'(a_if.max_rate), mx);
    endtask

    task automatic consume(input string pfx);
        a_if.table_ready = 1'b1;
        tick();
        a_if.table_ready = 1'b0;
        check({pfx, "_tv_drop"}, int'(a_if.table_valid), 0);
    endtask

    initial begin
        rst              = 1'b1;
        a_if.rate_valid  = 1'b0;
        a_if.rate_in     = '0;
        a_if.table_ready = 1'b0;
        b_if.rate_valid  = 1'b0;
        b_if.rate_in     = '0;
        b_if.table_ready = 1'b0;
`ifdef SORT_FORCE_RATE_EN
        a_if.force_en    = 1'b0;
        a_if.force_rate  = '0;
        b_if.force_en    = 1'b0;
        b_if.force_rate  = '0;
`endif
        repeat (3) tick();
        check("rst_tv",    int'(a_if.table_valid), 0);
        check("rst_ov",    int'(a_if.overrun), 0);
        check("rst_freq1", int'(a_if.freq1), 0);
        check("rst_max",   int'(a_if.max_rate), 0);
        rst = 1'b0;
        tick();

        // Ready while idle must not disturb anything.
        a_if.table_ready = 1'b1;
        tick();
        a_if.table_ready = 1'b0;

        seq = '{2, 2, 2, 1, 1, 0, 3, 4};
        send8(seq);
        wait_tv(1'b0, lat);
        check("f1_lat", lat, 4);
        expect_table("f1", 1, 2, 3, 1, 1, 2);
        consume("f1");

        seq = '{0, 0, 4, 4, 1, 2, 3, 3};
        send8(seq);
        wait_tv(1'b0, lat);
        check("tie_lat", lat, 4);
        expect_table("tie", 2, 1, 1, 2, 2, 0);

        // Second frame ends while the tie table is still waiting.
        ov_cnt = 0;
        seq = '{1, 1, 1, 1, 1, 1, 1, 1};
        send8(seq);
        check("ov_at_k", int'(a_if.overrun), 1);
        tick();
        check("ov_clear", int'(a_if.overrun), 0);
        repeat (4) tick();
        check("ov_pulses", ov_cnt, 1);
        expect_table("ov_hold", 2, 1, 1, 2, 2, 0);
        consume("ov");

        seq = '{1, 1, 1, 7, 4, 4, 0, 2};
        for (int i = 0; i < 8; i++) begin
            a_if.rate_valid = 1'b1;
            a_if.rate_in    = rate_t'(seq[i]);
            tick();
            a_if.rate_valid = 1'b0;
            if (i == 3) repeat (2) tick();
        end
        wait_tv(1'b0, lat);
        check("f3_lat", lat, 4);
        expect_table("f3", 1, 3, 1, 0, 2, 1);
        consume("f3");

        seq = '{3, 3, 3, 3, 3, 3, 3, 3};
        send8(seq);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_tv",    int'(a_if.table_valid), 0);
        check("mrst_freq4", int'(a_if.freq4), 0);
        check("mrst_max",   int'(a_if.max_rate), 0);
        repeat (4) tick();
        check("mrst_no_tbl", int'(a_if.table_valid), 0);

        seq = '{4, 4, 4, 0, 1, 2, 3, 3};
        send8(seq);
        wait_tv(1'b0, lat);
        check("post_rst_lat", lat, 4);
        expect_table("post_rst", 1, 1, 1, 2, 3, 4);
        consume("post_rst");

`ifdef SORT_FORCE_RATE_EN
        a_if.force_en   = 1'b1;
        a_if.force_rate = rate_t'(6);
        seq = '{0, 0, 0, 0, 0, 0, 0, 0};
        send8(seq);
        a_if.force_en   = 1'b0;
        a_if.force_rate = '0;
        wait_tv(1'b0, lat);
        check("force_lat", lat, 4);
        expect_table("force", 8, 0, 0, 0, 0, 4);
        consume("force");
`endif

        b_if.rate_valid = 1'b1;
        b_if.rate_in    = rate_t'(3);
        repeat (65535) tick();
        b_if.rate_valid = 1'b0;
        wait_tv(1'b1, lat);
        check("sat_lat",   lat, 4);
        check("sat_freq4", int'(b_if.freq4), 255);
        check("sat_freq1", int'(b_if.freq1), 0);
        check("sat_max",   int'(b_if.max_rate), 3);
        check("sat_ov",    int'(b_if.overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
